voxel_scene_gen: RTL
====================

# voxel_scene_gen

Parametrised procedural scene generator for a cubic voxel volume of 2^GRID_BITS per axis. It scans the volume once in x-major/z-minor order and evaluates a runtime-loaded table of up to NUM_PRIMS primitives (sphere, box, x-slab) for each voxel. Clearing and primitive painting happen in a single pass. It drives a valid/ready write stream into the voxel memory and supports backpressure and abort.

## Interface
- GRID_BITS, 6, bits per axis coordinate; grid edge = 2^GRID_BITS
- NUM_PRIMS, 4, primitive table entries (≥1); IDX_W = max(1, $clog2(NUM_PRIMS))
- DATA_W, 64, voxel word width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begins a scan when idle
- abort  in  1  pulse; terminates a running scan
- busy  out  1  high from accepted start until scan end
- done  out  1  one-cycle pulse at scan end (normal or aborted)
- aborted  out  1  sticky; set on abort, cleared on next accepted start
- cfg_wr  in  1  primitive table write strobe
- cfg_idx  in  IDX_W  entry index
- cfg_kind  in  2  0 = disabled, 1 = sphere, 2 = box, 3 = x-slab
- cfg_center  in  3*GRID_BITS  {cx, cy, cz}
- cfg_extent  in  GRID_BITS  radius / half-size
- cfg_voxel  in  DATA_W  word written on hit
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts write
- wr_addr  out  3*GRID_BITS  {x, y, z}
- wr_data  out  DATA_W  voxel word
- wr_count  out  3*GRID_BITS+1  writes accepted this scan

## Operation
- States: IDLE, SCAN, DRAIN, FINISH.
- IDLE -> SCAN on start: x = y = z = 0, wr_count = 0, aborted = 0.
- SCAN issues one coordinate per non-stalled cycle. z increments fastest, then y, then x.
- SCAN -> DRAIN after coordinate (max, max, max) is issued.
- DRAIN waits for the pipeline to empty and the last write to be accepted, then -> FINISH.
- FINISH: done = 1, busy = 0, -> IDLE.
- Per primitive, with d = coord − center as signed GRID_BITS+1 and e = extent:
  - sphere hits when dx²+dy²+dz² ≤ e². The sum is 2*GRID_BITS+4 bits wide, so no overflow.
  - box hits when |dx|, |dy| and |dz| are all ≤ e.
  - x-slab hits when |dx| ≤ e. y and z are ignored.
  - A disabled entry never hits.
- Priority: among hit entries the highest index wins and wr_data = its cfg_voxel. With no hit, wr_data = 0.
- cfg_wr is honoured only in IDLE and is ignored while busy. After reset all entries are kind 0.
- abort in SCAN or DRAIN:
  - In-flight pipeline entries are discarded and wr_valid drops next cycle.
  - Exception: a write held with wr_valid = 1 completes its handshake first.
  - aborted = 1, then FINISH.
- abort in IDLE is ignored.
- start while busy is ignored. start and abort asserted in the same IDLE cycle: start is taken.
- wr_count increments on each wr_valid && wr_ready.

## Timing
- Pipeline:
  - Stage 1 registers coordinate and per-entry hit bits.
  - Stage 2 registers priority-selected wr_addr/wr_data/wr_valid.
  - A coordinate issued in cycle N appears on wr_valid in cycle N+2 if unstalled.
- Stall: while wr_valid && !wr_ready, the counter and both stages hold. wr_addr and wr_data stay stable until accepted.
- Throughput: one write per cycle with wr_ready held high.
- Full scan, default build, no stall: 2^(3*GRID_BITS) writes. done asserts 4 cycles after the cycle in which the last coordinate is issued.
- Reset values:
  - busy, done, aborted, wr_valid = 0.
  - wr_addr, wr_data, wr_count = 0.
  - All primitive kinds = 0. State = IDLE.
- Reset asserted mid-scan forces these values immediately, and the table is lost.

## Configuration
- VOXEL_GEN_SKIP_EMPTY_EN defined:
  - Voxels with no hit produce no write (wr_valid stays low for that slot).
  - The memory keeps prior contents, so only primitives are painted.
  - wr_count counts hits only.
- Undefined: every voxel is written and misses write 0 (clear + paint).

## Test plan
- GRID_BITS=3, empty table, start, wr_ready=1 -> 512 writes, addresses 0..511 in order, all data 0, wr_count=512, done once. Same with SKIP_EMPTY -> 0 writes, done still pulses.
- Sphere idx0 center (4,4,4) e=1, voxel 0xA5 -> exactly 7 voxels carry 0xA5 (center plus 6 neighbours). (3,3,4) is written 0.
- Box idx0 center (2,2,2) e=1 → 0x11; sphere idx1 center (3,3,3) e=1 → 0x22 -> (3,3,3) = 0x22, (2,2,2) = 0x11, (1,1,1) = 0x11. Box covers 27 voxels.
- Random wr_ready 50% duty -> address sequence identical to the unstalled run. wr_addr/wr_data stable during stall. No write lost or duplicated.
- abort at write 100 with wr_ready low -> held write completes on ready, no further writes, aborted=1, done pulse, busy=0. A new start clears aborted.
- cfg_wr while busy changes nothing. rst_n low mid-scan -> wr_valid=0 immediately, table cleared, state IDLE.

Source files
------------

// File: rtl/voxel_scene_gen.sv
// voxel_scene_gen: procedural voxel scene generator.
// Scans a cubic volume of 2^GRID_BITS per axis in x-major / z-minor order and
// streams one word per voxel to memory through a valid/ready write port. Each
// voxel is tested against a runtime-loaded table of primitives (sphere, box,
// x-slab). The highest-index hit supplies the voxel word. A miss writes zero, so
// the scan clears and paints in one pass.
// Optional feature: define VOXEL_GEN_SKIP_EMPTY_EN to suppress writes for
// voxels with no hit, so that only primitives are painted.
module voxel_scene_gen #(
    parameter int unsigned GRID_BITS = 6,
    parameter int unsigned NUM_PRIMS = 4,
    parameter int unsigned DATA_W    = 64,
    localparam int unsigned IDX_W    = (NUM_PRIMS > 1) ? $clog2(NUM_PRIMS) : 1,
    localparam int unsigned COORD_W  = 3 * GRID_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    input  logic                 cfg_wr,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [1:0]           cfg_kind,
    input  logic [COORD_W-1:0]   cfg_center,
    input  logic [GRID_BITS-1:0] cfg_extent,
    input  logic [DATA_W-1:0]    cfg_voxel,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [COORD_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic [COORD_W:0]     wr_count
);

    // Squared distances of up to three axes, with headroom so the sum cannot wrap.
    localparam int unsigned SQ_W = 2 * GRID_BITS + 4;

    localparam logic [1:0] KindSphere = 2'd1;
    localparam logic [1:0] KindBox    = 2'd2;
    localparam logic [1:0] KindSlab   = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StFinish
    } state_e;

    state_e state_q, state_d;

    // Primitive table
    logic [1:0]           kind_q   [NUM_PRIMS];
    logic [COORD_W-1:0]   center_q [NUM_PRIMS];
    logic [GRID_BITS-1:0] extent_q [NUM_PRIMS];
    logic [DATA_W-1:0]    voxel_q  [NUM_PRIMS];

    // Scan counter, packed {x, y, z}; z is the low field so +1 gives z-fastest order.
    logic [COORD_W-1:0]   coord_q;
    logic [GRID_BITS-1:0] cur_x, cur_y, cur_z;

    // Stage 1: coordinate plus per-entry hit bits
    logic                 s1_valid;
    logic [COORD_W-1:0]   s1_addr;
    logic [NUM_PRIMS-1:0] s1_hit;

    logic [NUM_PRIMS-1:0] hit;
    logic [DATA_W-1:0]    sel_data;
    logic                 s1_emit;
    logic                 stall;
    logic                 issue;
    logic                 abort_take;
    logic                 last_coord;

    function automatic logic [GRID_BITS:0] abs_diff(input logic [GRID_BITS-1:0] a,
                                                    input logic [GRID_BITS-1:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    function automatic logic [SQ_W-1:0] sq(input logic [GRID_BITS:0] v);
        return SQ_W'(v) * SQ_W'(v);
    endfunction

    assign cur_x = coord_q[COORD_W-1 -: GRID_BITS];
    assign cur_y = coord_q[2*GRID_BITS-1 -: GRID_BITS];
    assign cur_z = coord_q[GRID_BITS-1:0];

    assign stall      = wr_valid && !wr_ready;
    assign issue      = (state_q == StScan) && !stall;
    assign abort_take = abort && ((state_q == StScan) || (state_q == StDrain));
    assign last_coord = &coord_q;

    assign busy = (state_q == StScan) || (state_q == StDrain);
    assign done = (state_q == StFinish);

    // Table writes are only honoured while idle so a running scan sees a frozen table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PRIMS; i++) begin
                kind_q[i]   <= '0;
                center_q[i] <= '0;
                extent_q[i] <= '0;
                voxel_q[i]  <= '0;
            end
        end else if (cfg_wr && (state_q == StIdle)) begin
            for (int i = 0; i < NUM_PRIMS; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    kind_q[i]   <= cfg_kind;
                    center_q[i] <= cfg_center;
                    extent_q[i] <= cfg_extent;
                    voxel_q[i]  <= cfg_voxel;
                end
            end
        end
    end

    // Per-entry hit test against the coordinate being issued this cycle.
    for (genvar i = 0; i < NUM_PRIMS; i++) begin : g_prim
        logic [GRID_BITS:0] ax, ay, az, ae;
        logic [SQ_W-1:0]    dist_sq, ext_sq;
        logic               in_sphere, in_box, in_slab;

        assign ax = abs_diff(cur_x, center_q[i][COORD_W-1 -: GRID_BITS]);
        assign ay = abs_diff(cur_y, center_q[i][2*GRID_BITS-1 -: GRID_BITS]);
        assign az = abs_diff(cur_z, center_q[i][GRID_BITS-1:0]);
        assign ae = {1'b0, extent_q[i]};

        assign dist_sq   = sq(ax) + sq(ay) + sq(az);
        assign ext_sq    = sq(ae);
        assign in_sphere = (dist_sq <= ext_sq);
        assign in_slab   = (ax <= ae);
        assign in_box    = in_slab && (ay <= ae) && (az <= ae);

        assign hit[i] = (kind_q[i] == KindSphere) ? in_sphere :
                        (kind_q[i] == KindBox)    ? in_box    :
                        (kind_q[i] == KindSlab)   ? in_slab   : 1'b0;
    end

    // Priority select: later (higher-index) hits override earlier ones.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_PRIMS; i++) begin
            if (s1_hit[i]) begin
                sel_data = voxel_q[i];
            end
        end
    end

`ifdef VOXEL_GEN_SKIP_EMPTY_EN
    assign s1_emit = s1_valid && (|s1_hit);
`else
    assign s1_emit = s1_valid;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DRAIN waits until both stages are empty before finishing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (abort_take || (issue && last_coord)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!s1_valid && !wr_valid) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Scan counter, accepted-write counter and sticky abort flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coord_q  <= '0;
            wr_count <= '0;
            aborted  <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            coord_q  <= '0;
            wr_count <= '0;
            aborted  <= 1'b0;
        end else begin
            if (issue && !abort_take) begin
                coord_q <= coord_q + COORD_W'(1);
            end
            if (wr_valid && wr_ready) begin
                wr_count <= wr_count + (COORD_W + 1)'(1);
            end
            if (abort_take) begin
                aborted <= 1'b1;
            end
        end
    end

    // Stage 1: capture issued coordinate and hit vector; abort discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_hit   <= '0;
        end else if (abort_take) begin
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= issue;
            if (issue) begin
                s1_addr <= coord_q;
                s1_hit  <= hit;
            end
        end
    end

    // Stage 2: output register. A stalled write is held through an abort until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else if (!stall) begin
            if (abort_take) begin
                wr_valid <= 1'b0;
            end else begin
                wr_valid <= s1_emit;
                if (s1_emit) begin
                    wr_addr <= s1_addr;
                    wr_data <= sel_data;
                end
            end
        end
    end

endmodule
